// File: rtl/nco_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nco_phase_scheduler
//  Description : Multi-channel NCO phase sequencer. One registered mod-360
//                stage is time-shared round-robin among NUM_CH phase
//                accumulators. Each result goes out over valid/ready.
//                Optional macro NCO_WRAP_FLAG_EN adds the out_wrap output.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_phase_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [15:0]       cfg_step,
    input  logic [8:0]        cfg_phase,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        out_phase,
    output logic [CH_W-1:0]   out_ch,
    output logic              busy
`ifdef NCO_WRAP_FLAG_EN
    ,
    output logic              out_wrap
`endif
);

    localparam int              c_cw1      = CH_W + 1;
    localparam logic [CH_W:0]   c_num_ch   = c_cw1'(NUM_CH);
    localparam logic [CH_W-1:0] c_last_ch  = CH_W'(NUM_CH - 1);
    localparam logic [16:0]     c_mod17    = 17'd360;
    localparam logic [8:0]      c_mod9     = 9'd360;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_MOD   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [8:0]        r_phase_q [NUM_CH];
    logic [8:0]        w_phase_d [NUM_CH];
    logic [15:0]       r_step_q  [NUM_CH];
    logic [15:0]       w_step_d  [NUM_CH];
    logic [CH_W-1:0]   r_rr_q,        w_rr_d;
    logic [CH_W-1:0]   r_ch_q,        w_ch_d;
    logic [16:0]       r_sum_q,       w_sum_d;
    logic              r_out_valid_q, w_out_valid_d;
    logic [8:0]        r_out_phase_q, w_out_phase_d;
    logic [CH_W-1:0]   r_out_ch_q,    w_out_ch_d;
`ifdef NCO_WRAP_FLAG_EN
    logic              r_out_wrap_q,  w_out_wrap_d;
`endif

    logic              w_found;
    logic [CH_W-1:0]   w_pick;
    logic [CH_W:0]     w_idx;
    logic [16:0]       w_new_sum;
    logic [8:0]        w_cfg_phase_red;
    logic              w_cfg_hit;

    // Round-robin pick: first enabled channel at or after r_rr_q, circularly.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_rr_q} + c_cw1'(i);
            if (w_idx >= c_num_ch) begin
                w_idx = w_idx - c_num_ch;
            end
            if (!w_found && ch_en[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[CH_W-1:0];
            end
        end
    end

    // Operand add (never overflows 17 bits) and preload reduction; the preload
    // is at most 511 so a single conditional subtract reduces it fully.
    always_comb begin
        w_new_sum       = {8'b0, r_phase_q[w_pick]} + {1'b0, r_step_q[w_pick]};
        w_cfg_phase_red = (cfg_phase >= c_mod9) ? (cfg_phase - c_mod9) : cfg_phase;
        w_cfg_hit       = cfg_we && ({1'b0, cfg_ch} < c_num_ch);
    end

    // Next-state logic; a config write is applied last so it wins over the
    // write-back of a handshaking result on the same channel.
    always_comb begin
        w_state_d     = r_state_q;
        w_phase_d     = r_phase_q;
        w_step_d      = r_step_q;
        w_rr_d        = r_rr_q;
        w_ch_d        = r_ch_q;
        w_sum_d       = r_sum_q;
        w_out_valid_d = r_out_valid_q;
        w_out_phase_d = r_out_phase_q;
        w_out_ch_d    = r_out_ch_q;
`ifdef NCO_WRAP_FLAG_EN
        w_out_wrap_d  = r_out_wrap_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (|ch_en) begin
                    w_state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_found) begin
                    w_ch_d    = w_pick;
                    w_sum_d   = w_new_sum;
                    w_state_d = S_MOD;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_MOD: begin
                w_out_phase_d = 9'(r_sum_q % c_mod17);
                w_out_ch_d    = r_ch_q;
                w_out_valid_d = 1'b1;
`ifdef NCO_WRAP_FLAG_EN
                w_out_wrap_d  = (r_sum_q >= c_mod17);
`endif
                w_state_d     = S_OUT;
            end
            default: begin
                if (out_ready) begin
                    w_phase_d[r_out_ch_q] = r_out_phase_q;
                    w_rr_d        = (r_out_ch_q == c_last_ch) ? '0 : r_out_ch_q + 1'b1;
                    w_out_valid_d = 1'b0;
                    w_state_d     = S_ISSUE;
                end
            end
        endcase
        if (w_cfg_hit) begin
            w_step_d[cfg_ch]  = cfg_step;
            w_phase_d[cfg_ch] = w_cfg_phase_red;
        end
    end

    // State registers; reset aborts any in-flight result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                r_phase_q[i] <= '0;
                r_step_q[i]  <= '0;
            end
            r_rr_q        <= '0;
            r_ch_q        <= '0;
            r_sum_q       <= '0;
            r_out_valid_q <= 1'b0;
            r_out_phase_q <= '0;
            r_out_ch_q    <= '0;
`ifdef NCO_WRAP_FLAG_EN
            r_out_wrap_q  <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_phase_q     <= w_phase_d;
            r_step_q      <= w_step_d;
            r_rr_q        <= w_rr_d;
            r_ch_q        <= w_ch_d;
            r_sum_q       <= w_sum_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_phase_q <= w_out_phase_d;
            r_out_ch_q    <= w_out_ch_d;
`ifdef NCO_WRAP_FLAG_EN
            r_out_wrap_q  <= w_out_wrap_d;
`endif
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_phase = r_out_phase_q;
    assign out_ch    = r_out_ch_q;
    assign busy      = (r_state_q != S_IDLE);
`ifdef NCO_WRAP_FLAG_EN
    assign out_wrap  = r_out_wrap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nco_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_phase_scheduler
//  Description : Self-checking bench for nco_phase_scheduler. Expected results
//                are queued as stimulus is set up and compared at each
//                output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_phase_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [15:0]       cfg_step = '0;
    logic [8:0]        cfg_phase = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [8:0]        out_phase;
    logic [CH_W-1:0]   out_ch;
    logic              busy;
`ifdef NCO_WRAP_FLAG_EN
    logic              out_wrap;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic [8:0] ph;
        logic       wr;
    } exp_t;

    exp_t sb[$];

    nco_phase_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_step  (cfg_step),
        .cfg_phase (cfg_phase),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_phase (out_phase),
        .out_ch    (out_ch),
        .busy      (busy)
`ifdef NCO_WRAP_FLAG_EN
        ,
        .out_wrap  (out_wrap)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input logic [1:0] ch, input int ph, input logic wr);
        exp_t e;
        e.ch = ch;
        e.ph = 9'(ph);
        e.wr = wr;
        sb.push_back(e);
    endtask

    // One clock: score a pending handshake at the falling edge, then move to
    // just after the next rising edge.
    task automatic tick();
        exp_t e;
        logic ok;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got ch=%0d phase=%0d, required no output", out_ch, out_phase);
            end else begin
                e  = sb.pop_front();
                ok = (out_ch === e.ch) && (out_phase === e.ph);
`ifdef NCO_WRAP_FLAG_EN
                ok = ok && (out_wrap === e.wr);
`endif
                if (!ok) begin
                    n_fail++;
                    $display("FAIL sb_result: got ch=%0d phase=%0d, required ch=%0d phase=%0d (wrap %0b)",
                             out_ch, out_phase, e.ch, e.ph, e.wr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        ch_en     = '0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        sb.delete();
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] step, input logic [8:0] ph);
        cfg_ch    = ch;
        cfg_step  = step;
        cfg_phase = ph;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Run until every queued result has been seen, then stop and go idle.
    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        ch_en = '0;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
        tick();
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: got valid=%0b busy=%0b, required 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ch_en = '0;
        tick();
        n_tests++;
        if ({out_valid, out_phase, out_ch, busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%0b phase=%0d ch=%0d busy=%0b, required all 0",
                     out_valid, out_phase, out_ch, busy);
        end
`ifdef NCO_WRAP_FLAG_EN
        n_tests++;
        if (out_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wrap: got %0b, required 0", out_wrap);
        end
`endif
        rst = 1'b0;
        tick();
        n_tests++;
        if ({out_valid, out_phase, out_ch, busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%0b phase=%0d ch=%0d busy=%0b, required all 0",
                     out_valid, out_phase, out_ch, busy);
        end
    endtask

    task automatic test_single_channel();
        int exp_ph[8] = '{50, 100, 150, 200, 250, 300, 350, 40};
        int vcyc[$];
        int c0;
        apply_reset();
        cfg_write(2'd0, 16'd50, 9'd0);
        for (int i = 0; i < 8; i++) push_exp(2'd0, exp_ph[i], (i == 7));
        ch_en = 4'b0001;
        c0    = cyc;
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            if (out_valid) vcyc.push_back(cyc);
            tick();
        end
        ch_en = '0;
        n_tests++;
        if (vcyc.size() != 8) begin
            n_fail++;
            $display("FAIL single_count: got %0d results, required 8", vcyc.size());
        end
        if (vcyc.size() > 0) begin
            n_tests++;
            if (vcyc[0] - c0 != 3) begin
                n_fail++;
                $display("FAIL single_latency: got %0d cycles, required 3", vcyc[0] - c0);
            end
        end
        for (int i = 1; i < vcyc.size(); i++) begin
            n_tests++;
            if (vcyc[i] - vcyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL single_interval: got %0d cycles, required 3", vcyc[i] - vcyc[i-1]);
            end
        end
        drain("single");
    endtask

    task automatic test_step_edges();
        apply_reset();
        cfg_write(2'd0, 16'd360, 9'd0);
        push_exp(2'd0, 0, 1'b1);
        push_exp(2'd0, 0, 1'b1);
        push_exp(2'd0, 0, 1'b1);
        ch_en = 4'b0001;
        drain("step360");
        cfg_write(2'd0, 16'd361, 9'd0);
        push_exp(2'd0, 1, 1'b1);
        push_exp(2'd0, 2, 1'b1);
        push_exp(2'd0, 3, 1'b1);
        ch_en = 4'b0001;
        drain("step361");
        cfg_write(2'd0, 16'hFFFF, 9'd0);
        push_exp(2'd0, 15, 1'b1);
        push_exp(2'd0, 30, 1'b1);
        ch_en = 4'b0001;
        drain("stepmax");
    endtask

    task automatic test_two_channels();
        apply_reset();
        cfg_write(2'd0, 16'd10, 9'd0);
        cfg_write(2'd2, 16'd20, 9'd0);
        push_exp(2'd0, 10, 1'b0);
        push_exp(2'd2, 20, 1'b0);
        push_exp(2'd0, 20, 1'b0);
        push_exp(2'd2, 40, 1'b0);
        ch_en = 4'b0101;
        drain("two_ch");
    endtask

    task automatic test_stall();
        apply_reset();
        cfg_write(2'd0, 16'd7, 9'd0);
        push_exp(2'd0, 7, 1'b0);
        push_exp(2'd0, 14, 1'b0);
        out_ready = 1'b0;
        ch_en     = 4'b0001;
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_wait: got valid=%0b, required 1", out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_phase !== 9'd7 || out_ch !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%0b phase=%0d ch=%0d, required 1 7 0",
                         out_valid, out_phase, out_ch);
            end
        end
        out_ready = 1'b1;
        drain("stall");
    endtask

    task automatic test_cfg_collision();
        apply_reset();
        cfg_write(2'd0, 16'd1, 9'd359);
        push_exp(2'd0, 0, 1'b1);
        ch_en = 4'b0001;
        drain("wrap");
        cfg_write(2'd0, 16'd0, 9'd400);
        push_exp(2'd0, 40, 1'b0);
        ch_en = 4'b0001;
        drain("preload");
        cfg_write(2'd0, 16'd5, 9'd0);
        push_exp(2'd0, 5, 1'b0);
        push_exp(2'd0, 105, 1'b0);
        push_exp(2'd0, 110, 1'b0);
        ch_en = 4'b0001;
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_wait: got valid=%0b, required 1", out_valid);
        end
        cfg_ch    = 2'd0;
        cfg_step  = 16'd5;
        cfg_phase = 9'd100;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        drain("collide");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cfg_write(2'd1, 16'd0, 9'd77);
        cfg_write(2'd2, 16'd0, 9'd200);
        cfg_write(2'd0, 16'd30, 9'd10);
        ch_en = 4'b0001;
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: got busy=%0b valid=%0b, required 1 0", busy, out_valid);
        end
        rst   = 1'b1;
        ch_en = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_phase !== 9'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got valid=%0b busy=%0b phase=%0d, required 0 0 0",
                     out_valid, busy, out_phase);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got valid=%0b busy=%0b, required 0 0", out_valid, busy);
        end
        for (int c = 0; c < 4; c++) push_exp(2'(c), 0, 1'b0);
        ch_en = 4'b1111;
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_step_edges();
        test_two_channels();
        test_stall();
        test_cfg_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
